// File: rtl/mac_result_fifo.sv
// rtl/mac_result_fifo.sv - first-word fall-through result FIFO behind the multiply-add stage
//
// Purpose:
//   Buffers signed results from the a*b + c*d + e stage so the producer can keep issuing
//   while the consumer stalls. Entries leave in strict arrival order; the head entry is
//   presented on out_y one cycle after it is written into an empty FIFO (no bypass).
//
// Ports:
//   tb_clk     clock, rising edge
//   tb_rst     asynchronous active-low reset; flushes all entries
//   in_valid   producer has a result on in_y
//   in_ready   FIFO has a free slot (registered state only)
//   in_y       result from producer
//   out_valid  head entry available on out_y
//   out_ready  consumer accepts head entry
//   out_y      head entry, zero when empty
//   count      entries held, 0..DEPTH
//   chk_sum    (MAC_FIFO_CHECKSUM_EN) running modulo-2^WIDTH sum of popped entries
//   chk_cnt    (MAC_FIFO_CHECKSUM_EN) number of popped entries, wraps at 2^16
//
// Optional feature macro: MAC_FIFO_CHECKSUM_EN
module mac_result_fifo #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              tb_clk,
    input  logic              tb_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_y,
`ifdef MAC_FIFO_CHECKSUM_EN
    output logic [ADDR_W:0]   count,
    output logic [WIDTH-1:0]  chk_sum,
    output logic [15:0]       chk_cnt
`else
    output logic [ADDR_W:0]   count
`endif
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push;
    logic              pop;

    // Flags come from the registered count only, so in_ready never depends on out_ready.
    assign in_ready  = (count_q != (ADDR_W+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_y     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge tb_clk or negedge tb_rst) begin
        if (!tb_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only visible through count/rd_ptr.
    always_ff @(posedge tb_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_y;
        end
    end

`ifdef MAC_FIFO_CHECKSUM_EN
    logic [WIDTH-1:0] chk_sum_q, chk_sum_d;
    logic [15:0]      chk_cnt_q, chk_cnt_d;

    always_comb begin
        chk_sum_d = chk_sum_q;
        chk_cnt_d = chk_cnt_q;
        if (pop) begin
            chk_sum_d = chk_sum_q + out_y;
            chk_cnt_d = chk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge tb_clk or negedge tb_rst) begin
        if (!tb_rst) begin
            chk_sum_q <= '0;
            chk_cnt_q <= '0;
        end else begin
            chk_sum_q <= chk_sum_d;
            chk_cnt_q <= chk_cnt_d;
        end
    end

    assign chk_sum = chk_sum_q;
    assign chk_cnt = chk_cnt_q;
`endif

endmodule

// File: tb/tb_mac_result_fifo.sv
// tb/tb_mac_result_fifo.sv - self-checking bench for mac_result_fifo
module tb_mac_result_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic        tb_clk    = 1'b0;
    logic        tb_rst    = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_y      = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_y;
    logic [2:0]  count;
`ifdef MAC_FIFO_CHECKSUM_EN
    logic [31:0] chk_sum;
    logic [15:0] chk_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: an ordered queue of held entries plus running checksum.
    logic [31:0] mq[$];
    logic [31:0] m_sum;
    logic [15:0] m_cnt;

    typedef struct packed {
        logic        iv;
        logic        orr;
        logic [31:0] y;
        logic        ev;
        logic [31:0] ey;
        logic [2:0]  ec;
        logic        eir;
    } vec_t;

    vec_t vecs[17];

    always #5 tb_clk = ~tb_clk;

    mac_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .tb_clk    (tb_clk),
        .tb_rst    (tb_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
`ifdef MAC_FIFO_CHECKSUM_EN
        .count     (count),
        .chk_sum   (chk_sum),
        .chk_cnt   (chk_cnt)
`else
        .count     (count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic orr, input logic [31:0] y,
                                input logic ev, input logic [31:0] ey, input logic [2:0] ec,
                                input logic eir);
        vec_t v;
        v.iv = iv; v.orr = orr; v.y = y; v.ev = ev; v.ey = ey; v.ec = ec; v.eir = eir;
        return v;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_sum = '0;
        m_cnt = '0;
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] head;
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        check({tag, "_count"}, 32'(count), 32'(mq.size()));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
        check({tag, "_out_y"}, out_y, head);
`ifdef MAC_FIFO_CHECKSUM_EN
        check({tag, "_chk_sum"}, chk_sum, m_sum);
        check({tag, "_chk_cnt"}, 32'(chk_cnt), 32'(m_cnt));
`endif
    endtask

    // Drives one cycle of inputs, advances the model by the handshake rules and compares after the edge.
    task automatic step(input logic iv, input logic orr, input logic [31:0] y, input string tag);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        out_ready = orr;
        in_y      = y;
        do_push   = iv && (mq.size() != DEPTH);
        do_pop    = orr && (mq.size() != 0);
        @(posedge tb_clk);
        if (do_pop) begin
            m_sum = m_sum + mq[0];
            m_cnt = m_cnt + 16'd1;
            void'(mq.pop_front());
        end
        if (do_push) mq.push_back(y);
        #1;
        compare_model(tag);
    endtask

    task automatic reset_dut();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_y      = '0;
        tb_rst    = 1'b0;
        @(posedge tb_clk);
        #1;
        tb_rst = 1'b1;
        model_clear();
    endtask

    initial begin
        model_clear();

        // Reset held for two cycles.
        repeat (2) @(posedge tb_clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_y", out_y, 32'd0);
        tb_rst = 1'b1;

        // Fill, full-hold, drain, late accept, simultaneous push/pop at count 2, empty pop.
        vecs[0]  = mk(1, 0, 32'h1,  1, 32'h1,  3'd1, 1);
        vecs[1]  = mk(1, 0, 32'h2,  1, 32'h1,  3'd2, 1);
        vecs[2]  = mk(1, 0, 32'h3,  1, 32'h1,  3'd3, 1);
        vecs[3]  = mk(1, 0, 32'h4,  1, 32'h1,  3'd4, 0);
        vecs[4]  = mk(1, 0, 32'h5,  1, 32'h1,  3'd4, 0);
        vecs[5]  = mk(0, 1, 32'h0,  1, 32'h2,  3'd3, 1);
        vecs[6]  = mk(0, 1, 32'h0,  1, 32'h3,  3'd2, 1);
        vecs[7]  = mk(0, 1, 32'h0,  1, 32'h4,  3'd1, 1);
        vecs[8]  = mk(0, 1, 32'h0,  0, 32'h0,  3'd0, 1);
        vecs[9]  = mk(1, 0, 32'h5,  1, 32'h5,  3'd1, 1);
        vecs[10] = mk(0, 1, 32'h0,  0, 32'h0,  3'd0, 1);
        vecs[11] = mk(1, 0, 32'h20, 1, 32'h20, 3'd1, 1);
        vecs[12] = mk(1, 0, 32'h21, 1, 32'h20, 3'd2, 1);
        vecs[13] = mk(1, 1, 32'h22, 1, 32'h21, 3'd2, 1);
        vecs[14] = mk(0, 1, 32'h0,  1, 32'h22, 3'd1, 1);
        vecs[15] = mk(0, 1, 32'h0,  0, 32'h0,  3'd0, 1);
        vecs[16] = mk(0, 1, 32'h0,  0, 32'h0,  3'd0, 1);

        for (int i = 0; i < 17; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].orr;
            in_y      = vecs[i].y;
            @(posedge tb_clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_out_y", i), out_y, vecs[i].ey);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ec));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
        end

        // Back-to-back stream with the consumer always ready; pointers wrap repeatedly.
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 32'h10 + 32'(i), "stream");
            check("stream_head", out_y, 32'h10 + 32'(i));
        end
        step(1'b0, 1'b1, 32'h0, "stream_tail");

        // Reset asserted between edges with three entries held.
        reset_dut();
        step(1'b1, 1'b0, 32'hA1, "pre_rst");
        step(1'b1, 1'b0, 32'hA2, "pre_rst");
        step(1'b1, 1'b0, 32'hA3, "pre_rst");
        in_valid = 1'b0;
        #2;
        tb_rst = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_y", out_y, 32'd0);
        #2;
        tb_rst = 1'b1;
        model_clear();
        step(1'b1, 1'b0, 32'hDEADBEEF, "post_rst");
        check("post_rst_head", out_y, 32'hDEADBEEF);
        step(1'b0, 1'b1, 32'h0, "post_rst_pop");

`ifdef MAC_FIFO_CHECKSUM_EN
        // Checksum crossing the signed boundary.
        reset_dut();
        step(1'b1, 1'b0, 32'h7FFFFFFF, "chk");
        step(1'b1, 1'b0, 32'h00000002, "chk");
        step(1'b0, 1'b1, 32'h0, "chk");
        step(1'b0, 1'b1, 32'h0, "chk");
        check("chk_sum_final", chk_sum, 32'h80000001);
        check("chk_cnt_final", 32'(chk_cnt), 32'd2);
`endif

        // Randomized traffic: alternate consumer-heavy and producer-heavy phases.
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            logic iv;
            logic orr;
            if ((i / 50) % 2 == 0) begin
                iv  = ($urandom_range(0, 3) != 0);
                orr = ($urandom_range(0, 3) == 0);
            end else begin
                iv  = ($urandom_range(0, 3) == 0);
                orr = ($urandom_range(0, 3) != 0);
            end
            step(iv, orr, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
